// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit.
// Holds the fetch FSM state enum, the bubble encoding and the PC step.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;
    localparam int          PC_STEP    = 4;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: issues one instruction-memory request at a time and
// presents the fetched (PC, instruction) pair to the IF/ID register.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   next_select/jal_target   jal redirect (decode)
//   branch_result/.._target  branch redirect (execute), highest priority
//   Jalr/jalr_target         jalr redirect
//   load                     load-use stall
//   imem_req/addr/gnt        request channel
//   imem_rvalid/rdata        response channel
//   pre_address_fetch        PC of the presented instruction
//   instruction_fetch        presented instruction, 0 = bubble
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                INSTRUCTION = 32,
    parameter int                ADDRESS     = 32,
    parameter logic [ADDRESS-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   next_select,
    input  logic                   branch_result,
    input  logic                   Jalr,
    input  logic                   load,
    input  logic [ADDRESS-1:0]     jal_target,
    input  logic [ADDRESS-1:0]     branch_target,
    input  logic [ADDRESS-1:0]     jalr_target,
    output logic                   imem_req,
    output logic [ADDRESS-1:0]     imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTRUCTION-1:0] imem_rdata,
    output logic [ADDRESS-1:0]     pre_address_fetch,
    output logic [INSTRUCTION-1:0] instruction_fetch
);

    localparam logic [INSTRUCTION-1:0] BUBBLE   = INSTRUCTION'(NOP_BUBBLE);
    localparam logic [ADDRESS-1:0]     STEP     = ADDRESS'(PC_STEP);
    localparam logic [ADDRESS-1:0]     ALIGN_MK = ~ADDRESS'(3);

    fetch_state_e       state;
    logic [ADDRESS-1:0] pc;
    logic [ADDRESS-1:0] req_pc;
    logic               kill;

    logic               redirect;
    logic               granted;
    logic [ADDRESS-1:0] target_raw;
    logic [ADDRESS-1:0] target;
    logic [ADDRESS-1:0] seq_pc;

    // Winning redirect target; low bits dropped so fetches stay word aligned.
    always_comb begin
        target_raw = jal_target;
        priority case (1'b1)
            branch_result: target_raw = branch_target;
            Jalr:          target_raw = jalr_target;
            default:       target_raw = jal_target;
        endcase
        target = target_raw & ALIGN_MK;
    end

    assign redirect  = branch_result | Jalr | next_select;
    assign granted   = imem_req & imem_gnt;
    assign seq_pc    = pc + STEP;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_REQ;
            pc                <= RESET_PC;
            req_pc            <= RESET_PC;
            kill              <= 1'b0;
            imem_req          <= 1'b0;
            pre_address_fetch <= '0;
            instruction_fetch <= BUBBLE;
        end else begin
            // Presented slot is a one-cycle pulse unless held below.
            pre_address_fetch <= '0;
            instruction_fetch <= BUBBLE;

            unique case (state)
                ST_REQ: begin
                    // imem_req is low only in the first cycle after reset,
                    // so a stray gnt there is not a grant.
                    if (granted) begin
                        req_pc   <= pc;
                        kill     <= redirect;
                        imem_req <= 1'b0;
                        state    <= ST_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                    if (redirect) begin
                        pc <= target;
                    end else if (granted) begin
                        pc <= seq_pc;
                    end
                end

                ST_WAIT: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (kill || redirect) begin
                            state    <= ST_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            pre_address_fetch <= req_pc;
                            instruction_fetch <= imem_rdata;
                            if (load) begin
                                state <= ST_HOLD;
                            end else begin
                                state    <= ST_REQ;
                                imem_req <= 1'b1;
                            end
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (load && !redirect) begin
                        pre_address_fetch <= pre_address_fetch;
                        instruction_fetch <= instruction_fetch;
                    end else begin
                        state    <= ST_REQ;
                        imem_req <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_select = 1'b0;
    logic        branch_result = 1'b0;
    logic        Jalr = 1'b0;
    logic        load = 1'b0;
    logic [31:0] jal_target = '0;
    logic [31:0] branch_target = '0;
    logic [31:0] jalr_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pre_address_fetch;
    logic [31:0] instruction_fetch;

    pc_fetch_unit #(
        .INSTRUCTION(32),
        .ADDRESS    (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .next_select      (next_select),
        .branch_result    (branch_result),
        .Jalr             (Jalr),
        .load             (load),
        .jal_target       (jal_target),
        .branch_target    (branch_target),
        .jalr_target      (jalr_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .pre_address_fetch(pre_address_fetch),
        .instruction_fetch(instruction_fetch)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: fetch pointer, one outstanding transaction,
    // and the presented slot with its hold flag.
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_out;
    logic [31:0] m_out_addr;
    logic        m_out_kill;
    logic [31:0] m_paddr;
    logic [31:0] m_pdata;
    logic        m_hold;

    task automatic model_reset();
        m_pc       = 32'h0;
        m_req      = 1'b0;
        m_out      = 1'b0;
        m_out_addr = '0;
        m_out_kill = 1'b0;
        m_paddr    = '0;
        m_pdata    = '0;
        m_hold     = 1'b0;
    endtask

    task automatic model_update();
        logic        redir;
        logic        resp;
        logic [31:0] tgt;
        logic [31:0] na;
        logic [31:0] nd;
        logic        nh;
        redir = branch_result | Jalr | next_select;
        tgt   = branch_result ? branch_target :
                Jalr          ? jalr_target   : jal_target;
        tgt   = tgt & ~32'h3;
        resp  = m_out && imem_rvalid;
        na = '0;
        nd = '0;
        nh = 1'b0;
        if (m_hold && load && !redir) begin
            na = m_paddr;
            nd = m_pdata;
            nh = 1'b1;
        end
        if (resp && !m_out_kill && !redir) begin
            na = m_out_addr;
            nd = imem_rdata;
            nh = load;
        end
        if (resp) m_out = 1'b0;
        else if (m_out && redir) m_out_kill = 1'b1;
        if (m_req && imem_gnt) begin
            m_out      = 1'b1;
            m_out_addr = m_pc;
            m_out_kill = redir;
            m_pc       = m_pc + 32'd4;
        end
        if (redir) m_pc = tgt;
        m_paddr = na;
        m_pdata = nd;
        m_hold  = nh;
        m_req   = !m_out && !nh;
    endtask

    task automatic check_outputs();
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) check("imem_addr", imem_addr, m_pc);
        check("pc_out", pre_address_fetch, m_paddr);
        check("instr_out", instruction_fetch, m_pdata);
    endtask

    // Inputs are set before calling; outputs checked, then one clock.
    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_redirects();
        next_select   = 1'b0;
        branch_result = 1'b0;
        Jalr          = 1'b0;
    endtask

    // Run memory with grants withheld until the unit is requesting.
    task automatic go_req();
        int n;
        n = 0;
        imem_gnt = 1'b0;
        load     = 1'b0;
        clear_redirects();
        while (!m_req && n < 10) begin
            imem_rvalid = m_out;
            imem_rdata  = $urandom;
            tick();
            n++;
        end
        imem_rvalid = 1'b0;
        check("reach_req", {31'b0, m_req}, 32'd1);
    endtask

    task automatic redirect_jal(input logic [31:0] t);
        go_req();
        next_select = 1'b1;
        jal_target  = t;
        tick();
        clear_redirects();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_pc_out", pre_address_fetch, 32'h0);
        check("rst_instr", instruction_fetch, 32'h0);
        rst = 1'b0;
        tick();
        check("req_rise", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Free-running memory: gnt and rvalid immediately.
        imem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imem_rvalid = m_out;
            imem_rdata  = $urandom;
            tick();
        end
        imem_rvalid = 1'b0;

        // Branch beats jal in the same cycle.
        go_req();
        branch_result = 1'b1;
        branch_target = 32'h100;
        next_select   = 1'b1;
        jal_target    = 32'h200;
        tick();
        clear_redirects();
        check("br_over_jal", imem_addr, 32'h100);

        // Misaligned jalr target.
        go_req();
        Jalr        = 1'b1;
        jalr_target = 32'h103;
        tick();
        clear_redirects();
        check("jalr_align", imem_addr, 32'h100);

        // Grant withheld: request stays put.
        redirect_jal(32'h20);
        for (int i = 0; i < 4; i++) begin
            check("stall_addr", imem_addr, 32'h20);
            check("stall_req", {31'b0, imem_req}, 32'd1);
            tick();
        end

        // Redirect while waiting kills the response.
        redirect_jal(32'h8);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        next_select = 1'b1;
        jal_target  = 32'h40;
        tick();
        clear_redirects();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0093;
        tick();
        imem_rvalid = 1'b0;
        check("kill_instr", instruction_fetch, 32'h0);
        check("kill_pc", pre_address_fetch, 32'h0);
        check("kill_next", imem_addr, 32'h40);

        // Load stall holds the captured instruction.
        redirect_jal(32'hC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0113;
        load        = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("hold_pc", pre_address_fetch, 32'hC);
            check("hold_instr", instruction_fetch, 32'h0050_0113);
            check("hold_req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        load = 1'b0;
        tick();
        check("after_hold", imem_addr, 32'h10);
        check("after_hold_req", {31'b0, imem_req}, 32'd1);

        // PC wraps past the top of the address space.
        redirect_jal(32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("wrap_addr", imem_addr, 32'h0);

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                imem_rvalid = 1'b0;
                #1;
                model_reset();
                check_outputs();
                @(negedge clk);
                rst = 1'b0;
            end
            imem_gnt      = ($urandom_range(0, 2) != 0);
            imem_rvalid   = m_out && ($urandom_range(0, 1) == 1);
            imem_rdata    = $urandom;
            load          = ($urandom_range(0, 3) == 0);
            branch_result = ($urandom_range(0, 11) == 0);
            Jalr          = ($urandom_range(0, 11) == 0);
            next_select   = ($urandom_range(0, 11) == 0);
            branch_target = $urandom;
            jalr_target   = $urandom;
            jal_target    = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
